gpu_raster_writer: RTL and testbench



---
 rtl/gpu_raster_writer.sv | 204 ++++++++++++++++++++
 tb/tb_gpu_raster_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_raster_writer.sv
// Back-buffer pixel producer: clears the frame to a background level, then fills
// queued solid rectangles, one pixel per cycle, and answers the start/done swap handshake.
module gpu_raster_writer #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       gpu_clk_150,
   input  logic       reset,
   input  logic       gpu_start,
   output logic       gpu_done,
   output logic [9:0] gpu_x,
   output logic [9:0] gpu_y,
   output logic [3:0] gpu_data,
   output logic       gpu_we,
   input  logic [3:0] bg_color,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_x0,
   input  logic [9:0] cmd_y0,
   input  logic [9:0] cmd_x1,
   input  logic [9:0] cmd_y1,
   input  logic [3:0] cmd_color
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [9:0]    X_MAX    = 10'(H_RES - 1);
   localparam logic [9:0]    Y_MAX    = 10'(V_RES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [9:0] x0;
      logic [9:0] y0;
      logic [9:0] x1;
      logic [9:0] y1;
      logic [3:0] color;
   } rect_t;

   typedef enum logic [1:0] {IDLE, CLEAR, FETCH, DRAW} state_t;

   logic r_sync1, r_sync2, r_sync_d;
   logic w_start_edge;

   rect_t         r_mem [FIFO_DEPTH];
   rect_t         w_cmd_in, w_head;
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count, w_count_nxt;
   logic          w_push, w_pop;
   logic [9:0]    w_clip_x1, w_clip_y1;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_quota, w_quota_nxt;
   logic [9:0]    r_x, r_y, r_x0, r_x1, r_y1;
   logic [9:0]    w_x_nxt, w_y_nxt, w_x0_nxt, w_x1_nxt, w_y1_nxt;
   logic [3:0]    r_color, w_color_nxt;
   logic          w_done_nxt, w_we_nxt;
   logic [9:0]    w_gx_nxt, w_gy_nxt;
   logic [3:0]    w_gdata_nxt;

   // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge gpu_clk_150 or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync1  <= gpu_start;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_start_edge = r_sync2 & ~r_sync_d;

   assign w_cmd_in    = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
   assign w_head      = r_mem[r_rd_ptr];
   assign w_push      = cmd_valid & cmd_ready;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   assign w_clip_x1   = (w_head.x1 > X_MAX) ? X_MAX : w_head.x1;
   assign w_clip_y1   = (w_head.y1 > Y_MAX) ? Y_MAX : w_head.y1;

   // NOTE: FIFO storage is not reset; only pointers and count are, which is enough to mark it empty.
   always_ff @(posedge gpu_clk_150) begin
      if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
   end

   always_ff @(posedge gpu_clk_150 or negedge reset) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         cmd_ready <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count   <= w_count_nxt;
         cmd_ready <= (w_count_nxt != FULL_CNT);
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_quota_nxt = r_quota;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_x0_nxt    = r_x0;
      w_x1_nxt    = r_x1;
      w_y1_nxt    = r_y1;
      w_color_nxt = r_color;
      w_pop       = 1'b0;
      w_done_nxt  = 1'b0;
      w_we_nxt    = 1'b0;
      w_gx_nxt    = gpu_x;
      w_gy_nxt    = gpu_y;
      w_gdata_nxt = gpu_data;

      case (r_state)
         IDLE: begin
            w_done_nxt = 1'b1;
            if (w_start_edge) begin
               // Pixel (0,0) goes out on the launch cycle; the clear walk resumes at (1,0).
               w_done_nxt  = 1'b0;
               w_we_nxt    = 1'b1;
               w_gx_nxt    = '0;
               w_gy_nxt    = '0;
               w_gdata_nxt = bg_color;
               w_color_nxt = bg_color;
               w_x0_nxt    = '0;
               w_x1_nxt    = X_MAX;
               w_y1_nxt    = Y_MAX;
               w_x_nxt     = 10'd1;
               w_y_nxt     = '0;
               w_quota_nxt = r_count;
               w_state_nxt = CLEAR;
            end
         end
         CLEAR, DRAW: begin
            w_we_nxt    = 1'b1;
            w_gx_nxt    = r_x;
            w_gy_nxt    = r_y;
            w_gdata_nxt = r_color;
            if (r_x == r_x1) begin
               w_x_nxt = r_x0;
               if (r_y == r_y1) w_state_nxt = FETCH;
               else             w_y_nxt     = r_y + 10'd1;
            end else begin
               w_x_nxt = r_x + 10'd1;
            end
         end
         FETCH: begin
            if (r_quota == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_pop       = 1'b1;
               w_quota_nxt = r_quota - CW'(1);
               if ((w_head.x0 <= w_clip_x1) && (w_head.y0 <= w_clip_y1)) begin
                  w_x_nxt     = w_head.x0;
                  w_y_nxt     = w_head.y0;
                  w_x0_nxt    = w_head.x0;
                  w_x1_nxt    = w_clip_x1;
                  w_y1_nxt    = w_clip_y1;
                  w_color_nxt = w_head.color;
                  w_state_nxt = DRAW;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge gpu_clk_150 or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_quota  <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_x0     <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_color  <= '0;
         gpu_done <= 1'b1;
         gpu_we   <= 1'b0;
         gpu_x    <= '0;
         gpu_y    <= '0;
         gpu_data <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_quota  <= w_quota_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_x0     <= w_x0_nxt;
         r_x1     <= w_x1_nxt;
         r_y1     <= w_y1_nxt;
         r_color  <= w_color_nxt;
         gpu_done <= w_done_nxt;
         gpu_we   <= w_we_nxt;
         gpu_x    <= w_gx_nxt;
         gpu_y    <= w_gy_nxt;
         gpu_data <= w_gdata_nxt;
      end
   end

endmodule

// File: tb/tb_gpu_raster_writer.sv
// Scoreboard bench for gpu_raster_writer on a reduced raster: a frame-level model
// predicts every pixel write and the frame length; a monitor checks each write.
module tb_gpu_raster_writer;
   localparam int H = 64;
   localparam int V = 48;

   typedef struct {
      int x0;
      int y0;
      int x1;
      int y1;
      int c;
   } cmd_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gpu_start = 1'b0;
   logic       gpu_done, gpu_we, cmd_ready;
   logic [9:0] gpu_x, gpu_y;
   logic [3:0] gpu_data;
   logic [3:0] bg_color = '0;
   logic       cmd_valid = 1'b0;
   logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic [3:0] cmd_color = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fall_cyc = 0;
   int rise_cyc = 0;
   bit prev_done = 1'b1;

   logic [23:0] exp_q[$];
   cmd_t        cmd_q[$];

   gpu_raster_writer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(4)) dut (
      .gpu_clk_150(clk),
      .reset      (rst_n),
      .gpu_start  (gpu_start),
      .gpu_done   (gpu_done),
      .gpu_x      (gpu_x),
      .gpu_y      (gpu_y),
      .gpu_data   (gpu_data),
      .gpu_we     (gpu_we),
      .bg_color   (bg_color),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x0     (cmd_x0),
      .cmd_y0     (cmd_y0),
      .cmd_x1     (cmd_x1),
      .cmd_y1     (cmd_y1),
      .cmd_color  (cmd_color)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write must match the head of the expected stream.
   always @(negedge clk) begin
      logic [23:0] e;
      if (rst_n) begin
         if (gpu_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", {8'h0, gpu_x, gpu_y, gpu_data}, 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("pixel", {8'h0, gpu_x, gpu_y, gpu_data}, {8'h0, e});
            end
            if (gpu_done) check("done_during_write", 32'(gpu_done), 32'd0);
         end
         if (!gpu_done && prev_done) fall_cyc = cyc;
         if (gpu_done && !prev_done) rise_cyc = cyc;
         prev_done = gpu_done;
      end
   end

   // Reference model: whole-frame expected write stream plus write and fetch counts.
   task automatic build_frame(input logic [3:0] bg, output int w, output int f);
      int n;
      cmd_t c;
      int cx1, cy1;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            exp_q.push_back({10'(x), 10'(y), bg});
      w = H * V;
      n = cmd_q.size();
      f = n + 1;
      for (int i = 0; i < n; i++) begin
         c   = cmd_q.pop_front();
         cx1 = (c.x1 > H - 1) ? H - 1 : c.x1;
         cy1 = (c.y1 > V - 1) ? V - 1 : c.y1;
         if (c.x0 <= cx1 && c.y0 <= cy1) begin
            for (int y = c.y0; y <= cy1; y++)
               for (int x = c.x0; x <= cx1; x++)
                  exp_q.push_back({10'(x), 10'(y), 4'(c.c)});
            w += (cx1 - c.x0 + 1) * (cy1 - c.y0 + 1);
         end
      end
   endtask

   task automatic push_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
      int b = 0;
      while (!cmd_ready && b < 20000) begin
         @(posedge clk); #1;
         b++;
      end
      if (!cmd_ready) begin
         check("push_timeout", 32'd0, 32'd1);
         return;
      end
      cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
      cmd_color = 4'(c);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_q.push_back('{x0, y0, x1, y1, c});
   endtask

   task automatic push_rand();
      push_cmd($urandom_range(0, H + 4), $urandom_range(0, V + 4),
               $urandom_range(0, H + 200), $urandom_range(0, V + 200), $urandom_range(0, 15));
   endtask

   task automatic launch(input logic [3:0] bg, output int w, output int f, output bit ok);
      int t0, b;
      bg_color = bg;
      build_frame(bg, w, f);
      t0 = cyc;
      gpu_start = 1'b1;
      b = 0;
      while (fall_cyc <= t0 && b < 20) begin
         @(posedge clk); #1;
         b++;
      end
      gpu_start = 1'b0;
      ok = (fall_cyc > t0);
      if (!ok) begin
         check("start_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end
   endtask

   task automatic run_frame(input logic [3:0] bg, input bit mid_push);
      int w, f, b;
      bit ok;
      launch(bg, w, f, ok);
      if (!ok) return;
      if (mid_push) push_cmd(1, 2, 3, 4, 11);
      b = 0;
      while (rise_cyc <= fall_cyc && b < w + f + 100) begin
         @(posedge clk); #1;
         b++;
      end
      check("frame_finished", 32'(rise_cyc > fall_cyc), 32'd1);
      check("frame_cycles", 32'(rise_cyc - fall_cyc), 32'(w + f));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int w, f, b;
      bit ok;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_done", 32'(gpu_done), 32'd1);
      check("rst_we", 32'(gpu_we), 32'd0);
      check("rst_x", 32'(gpu_x), 32'd0);
      check("rst_y", 32'(gpu_y), 32'd0);
      check("rst_data", 32'(gpu_data), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);

      run_frame(4'd5, 1'b0);

      push_cmd(10, 20, 12, 21, 7);
      run_frame(4'd1, 1'b0);

      push_cmd(H - 2, V - 2, 400, 300, 3);
      run_frame(4'd2, 1'b0);

      push_cmd(50, 5, 40, 9, 6);
      push_cmd(0, 0, 0, 0, 9);
      run_frame(4'd0, 1'b0);
      run_frame(4'd8, 1'b0);

      for (int i = 0; i < 4; i++) push_rand();
      check("full_ready", 32'(cmd_ready), 32'd0);
      cmd_x0 = 10'd5; cmd_y0 = 10'd5; cmd_x1 = 10'd6; cmd_y1 = 10'd6; cmd_color = 4'd15;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("refused_ready", 32'(cmd_ready), 32'd0);
      run_frame(4'( 12), 1'b1);
      run_frame(4'(13), 1'b0);

      for (int fr = 0; fr < 3; fr++) begin
         int n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) push_rand();
         run_frame(4'($urandom_range(0, 15)), 1'b0);
      end

      push_cmd(5, 5, 10, 10, 2);
      launch(4'd4, w, f, ok);
      if (ok) begin
         b = 0;
         while (cyc - fall_cyc < 1000 && b < 1100) begin
            @(posedge clk); #1;
            b++;
         end
         #1 rst_n = 1'b0;
         #1;
         check("async_rst_we", 32'(gpu_we), 32'd0);
         check("async_rst_done", 32'(gpu_done), 32'd1);
         check("async_rst_ready", 32'(cmd_ready), 32'd1);
         check("async_rst_x", 32'(gpu_x), 32'd0);
      end
      exp_q.delete();
      cmd_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(4'd6, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
